// File: rtl/relay_pkg.sv
// Shared types and constants for the relay computer memory unit.
// Holds the memory FSM state, the bus operation code and the latched request record.
package relay_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 8;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } mem_state_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } mem_op_t;

    typedef struct packed {
        mem_op_t             op;
        logic [ADDR_W-1:0]   addr;
        logic [DATA_W-1:0]   wdat;
    } mem_req_t;

    // True when any address bit above the implemented array width is set.
    function automatic logic addr_out_of_range(input logic [ADDR_W-1:0] a, input int bits);
        logic [ADDR_W-1:0] upper;
        upper = (bits >= ADDR_W) ? '0 : (a >> bits);
        return (upper != '0);
    endfunction

endpackage

// File: rtl/relay_mem_array.sv
// Single-port synchronous RAM backing the memory unit; contents survive reset.
// Latency: registered read, data one clock after the address; write commits on the edge.
// Backpressure: none, accepts an access every clock.
module relay_mem_array
    import relay_pkg::*;
#(
    parameter int ADDR_BITS = 15
) (
    input  logic                 clock,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [DATA_W-1:0]    wdata,
    output logic [DATA_W-1:0]    rdata
);

    localparam int DEPTH = 2 ** ADDR_BITS;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clock) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
        rdata_q <= mem_q[addr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/relay_memory_responder.sv
// Memory-unit responder: serves sequencer MEM-READ/MEM-WRITE after a relay settle wait.
// Latency: ack SETTLE_CYCLES+1 clocks after capture; conflicting requests ack after 1.
// Backpressure: initiator holds the request until ack; ack holds until both requests drop.
module relay_memory_responder
    import relay_pkg::*;
#(
    parameter int ADDR_BITS     = 15,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              data_drive,
    output logic              mem_ack,
    output logic              mem_err,
    output logic              led_busy,
    output logic [ADDR_W-1:0] led_addr
);

    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    mem_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    mem_req_t          req_q, req_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              data_drive_q, data_drive_d;
    logic              mem_ack_q, mem_ack_d;
    logic              mem_err_q, mem_err_d;
    logic              led_busy_q, led_busy_d;
    logic [ADDR_W-1:0] led_addr_q, led_addr_d;
    logic              req_seen_low_q, req_seen_low_d;

    logic              ram_we;
    logic              ram_we_gated;
    logic [DATA_W-1:0] ram_rdata;
    logic              req_active;
    logic              req_none;
    logic              out_of_range;

    assign req_active   = (req_q.op == OP_READ) ? mem_read : mem_write;
    assign req_none     = !mem_read && !mem_write;
    assign out_of_range = addr_out_of_range(req_q.addr, ADDR_BITS);

    // Reset wins over a write whose ACCESS edge coincides with it.
    assign ram_we_gated = ram_we && reset;

    // The latched address is presented throughout SETTLE, so read data is ready in ACCESS.
    relay_mem_array #(
        .ADDR_BITS (ADDR_BITS)
    ) u_array (
        .clock (clock),
        .we    (ram_we_gated),
        .addr  (req_q.addr[ADDR_BITS-1:0]),
        .wdata (req_q.wdat),
        .rdata (ram_rdata)
    );

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        req_d          = req_q;
        data_out_d     = data_out_q;
        data_drive_d   = data_drive_q;
        mem_ack_d      = mem_ack_q;
        mem_err_d      = mem_err_q;
        led_addr_d     = led_addr_q;
        req_seen_low_d = req_seen_low_q;
        ram_we         = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_none) begin
                    req_seen_low_d = 1'b1;
                end else if (req_seen_low_q) begin
                    req_seen_low_d = 1'b0;
                    if (mem_read && mem_write) begin
                        mem_err_d    = 1'b1;
                        data_drive_d = 1'b0;
                        state_d      = DONE;
                    end else begin
                        req_d.op   = mem_write ? OP_WRITE : OP_READ;
                        req_d.addr = addr;
                        req_d.wdat = data_in;
                        led_addr_d = addr;
                        cnt_d      = SETTLE_LOAD;
                        state_d    = SETTLE;
                    end
                end
            end

            SETTLE: begin
                if (!req_active) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    state_d = ACCESS;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            ACCESS: begin
                mem_err_d = out_of_range;
                mem_ack_d = 1'b1;
                state_d   = DONE;
                if (req_q.op == OP_READ) begin
                    data_drive_d = 1'b1;
                    data_out_d   = out_of_range ? '0 : ram_rdata;
                end else begin
                    data_drive_d = 1'b0;
                    ram_we       = !out_of_range;
                end
            end

            DONE: begin
                if (req_none) begin
                    mem_ack_d    = 1'b0;
                    data_drive_d = 1'b0;
                    state_d      = IDLE;
                end else begin
                    // A conflict enters DONE without ack; it rises here one clock later.
                    mem_ack_d = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        led_busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            req_q          <= '0;
            data_out_q     <= '0;
            data_drive_q   <= 1'b0;
            mem_ack_q      <= 1'b0;
            mem_err_q      <= 1'b0;
            led_busy_q     <= 1'b0;
            led_addr_q     <= '0;
            req_seen_low_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            req_q          <= req_d;
            data_out_q     <= data_out_d;
            data_drive_q   <= data_drive_d;
            mem_ack_q      <= mem_ack_d;
            mem_err_q      <= mem_err_d;
            led_busy_q     <= led_busy_d;
            led_addr_q     <= led_addr_d;
            req_seen_low_q <= req_seen_low_d;
        end
    end

    assign data_out   = data_out_q;
    assign data_drive = data_drive_q;
    assign mem_ack    = mem_ack_q;
    assign mem_err    = mem_err_q;
    assign led_busy   = led_busy_q;
    assign led_addr   = led_addr_q;

endmodule

// File: tb/tb_relay_memory_responder.sv
// Scoreboard bench for relay_memory_responder: main instance with SETTLE_CYCLES=4,
// plus SETTLE_CYCLES=1 and 15 instances for the latency sweep.
module tb_relay_memory_responder;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] addr;
    logic [7:0]  data_in;
    logic        rd      [3];
    logic        wr      [3];
    logic [7:0]  dout    [3];
    logic        drive   [3];
    logic        ack     [3];
    logic        err     [3];
    logic        busy    [3];
    logic [15:0] ledaddr [3];

    always #5 clock = ~clock;

    relay_memory_responder #(.ADDR_BITS(15), .SETTLE_CYCLES(4)) dut (
        .clock(clock), .reset(reset), .mem_read(rd[0]), .mem_write(wr[0]),
        .addr(addr), .data_in(data_in), .data_out(dout[0]), .data_drive(drive[0]),
        .mem_ack(ack[0]), .mem_err(err[0]), .led_busy(busy[0]), .led_addr(ledaddr[0]));

    relay_memory_responder #(.ADDR_BITS(15), .SETTLE_CYCLES(1)) dut_s1 (
        .clock(clock), .reset(reset), .mem_read(rd[1]), .mem_write(wr[1]),
        .addr(addr), .data_in(data_in), .data_out(dout[1]), .data_drive(drive[1]),
        .mem_ack(ack[1]), .mem_err(err[1]), .led_busy(busy[1]), .led_addr(ledaddr[1]));

    relay_memory_responder #(.ADDR_BITS(15), .SETTLE_CYCLES(15)) dut_s15 (
        .clock(clock), .reset(reset), .mem_read(rd[2]), .mem_write(wr[2]),
        .addr(addr), .data_in(data_in), .data_out(dout[2]), .data_drive(drive[2]),
        .mem_ack(ack[2]), .mem_err(err[2]), .led_busy(busy[2]), .led_addr(ledaddr[2]));

    typedef struct {
        int         id;
        int         txn;
        int         lat;
        logic       err;
        logic       drv;
        logic       cd;
        logic [7:0] dout;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   txn      = 0;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h (t=%0t)", nm, act, exp_v, $time);
        end
    endfunction

    // Monitor: pops the scoreboard whenever an instance raises mem_ack.
    int   req_cyc  [3];
    logic req_prev [3];
    logic ack_prev [3];

    initial begin
        for (int i = 0; i < 3; i++) begin
            req_cyc[i]  = 0;
            req_prev[i] = 1'b0;
            ack_prev[i] = 1'b0;
        end
    end

    always @(negedge clock) begin
        exp_t e;
        logic r;
        for (int i = 0; i < 3; i++) begin
            r = rd[i] | wr[i];
            if (r && !req_prev[i]) req_cyc[i] = cyc;
            if (ack[i] === 1'b1 && !ack_prev[i]) begin
                if (sb.size() == 0) begin
                    chk("unexpected_ack", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk($sformatf("txn%0d_inst", e.txn), i, e.id);
                    chk($sformatf("txn%0d_latency", e.txn), cyc - req_cyc[i] - 1, e.lat);
                    chk($sformatf("txn%0d_mem_err", e.txn), err[i], e.err);
                    chk($sformatf("txn%0d_data_drive", e.txn), drive[i], e.drv);
                    if (e.cd) chk($sformatf("txn%0d_data_out", e.txn), dout[i], e.dout);
                end
            end
            if (drive[i] === 1'b1) chk("drive_implies_ack", ack[i], 1);
            req_prev[i] = r;
            ack_prev[i] = (ack[i] === 1'b1);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic run_op(input int id, input bit do_rd, input bit do_wr,
                          input logic [15:0] a, input logic [7:0] d, input int lat,
                          input logic e_err, input logic e_drv, input logic e_cd,
                          input logic [7:0] e_dout, input int hold);
        exp_t e;
        int   k;
        e = '{id, txn, lat, e_err, e_drv, e_cd, e_dout};
        sb.push_back(e);
        txn++;
        addr    = a;
        data_in = d;
        rd[id]  = do_rd;
        wr[id]  = do_wr;
        tick(1);
        addr    = ~a;
        data_in = ~d;
        k = 1;
        while (ack[id] !== 1'b1 && k < 40) begin
            tick(1);
            k++;
        end
        if (ack[id] !== 1'b1) begin
            chk("ack_timeout", 0, 1);
            e = sb.pop_back();
        end else begin
            chk("busy_in_done", busy[id], 1);
            if (!(do_rd && do_wr)) chk("led_addr", ledaddr[id], a);
            for (int h = 0; h < hold; h++) begin
                tick(1);
                chk("ack_held", ack[id], 1);
            end
        end
        rd[id] = 1'b0;
        wr[id] = 1'b0;
        tick(1);
        chk("ack_release", ack[id], 0);
        chk("drive_release", drive[id], 0);
        chk("busy_release", busy[id], 0);
        tick(1);
    endtask

    task automatic check_reset_outputs();
        chk("rst_data_out", dout[0], 8'h00);
        chk("rst_data_drive", drive[0], 0);
        chk("rst_mem_ack", ack[0], 0);
        chk("rst_mem_err", err[0], 0);
        chk("rst_led_busy", busy[0], 0);
        chk("rst_led_addr", ledaddr[0], 16'h0000);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int saw;
        reset   = 1'b0;
        addr    = '0;
        data_in = '0;
        for (int i = 0; i < 3; i++) begin
            rd[i] = 1'b0;
            wr[i] = 1'b0;
        end
        tick(3);
        check_reset_outputs();
        reset = 1'b1;
        tick(2);

        // Write then read back.
        run_op(0, 0, 1, 16'h0123, 8'hA5, 5, 0, 0, 0, 8'h00, 0);
        run_op(0, 1, 0, 16'h0123, 8'h00, 5, 0, 1, 1, 8'hA5, 0);

        // Preload known contents.
        run_op(0, 0, 1, 16'h0010, 8'h5A, 5, 0, 0, 0, 8'h00, 0);
        run_op(0, 0, 1, 16'h0020, 8'h42, 5, 0, 0, 0, 8'h00, 0);
        run_op(0, 0, 1, 16'h0030, 8'h99, 5, 0, 0, 0, 8'h00, 0);
        run_op(0, 0, 1, 16'h7FFF, 8'hC3, 5, 0, 0, 0, 8'h00, 0);

        // Out of range read and write; the write must not alias onto 7FFF.
        run_op(0, 1, 0, 16'h8000, 8'h00, 5, 1, 1, 1, 8'h00, 0);
        run_op(0, 0, 1, 16'hFFFF, 8'h3C, 5, 1, 0, 0, 8'h00, 0);
        run_op(0, 1, 0, 16'h7FFF, 8'h00, 5, 0, 1, 1, 8'hC3, 0);

        // Conflicting requests: ack after one clock, error, no array change.
        run_op(0, 1, 1, 16'h0123, 8'hFF, 1, 1, 0, 0, 8'h00, 0);
        run_op(0, 1, 0, 16'h0123, 8'h00, 5, 0, 1, 1, 8'hA5, 0);

        // Abort: write dropped two clocks into SETTLE.
        addr = 16'h0010; data_in = 8'h11; wr[0] = 1'b1;
        tick(1);
        tick(2);
        wr[0] = 1'b0;
        saw = 0;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            if (ack[0] === 1'b1) saw = 1;
        end
        chk("abort_no_ack", saw, 0);
        chk("abort_idle", busy[0], 0);
        run_op(0, 1, 0, 16'h0010, 8'h00, 5, 0, 1, 1, 8'h5A, 0);

        // Reset during SETTLE with the write request held through and after reset.
        addr = 16'h0020; data_in = 8'h77; wr[0] = 1'b1;
        tick(1);
        tick(2);
        reset = 1'b0;
        tick(2);
        check_reset_outputs();
        reset = 1'b1;
        saw = 0;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            if (ack[0] === 1'b1 || busy[0] === 1'b1) saw = 1;
        end
        chk("held_no_recapture", saw, 0);
        wr[0] = 1'b0;
        tick(2);
        run_op(0, 1, 0, 16'h0020, 8'h00, 5, 0, 1, 1, 8'h42, 0);
        run_op(0, 1, 0, 16'h0123, 8'h00, 5, 0, 1, 1, 8'hA5, 0);

        // Reset landing exactly on the ACCESS edge of a write.
        addr = 16'h0030; data_in = 8'hEE; wr[0] = 1'b1;
        tick(1);
        tick(4);
        reset = 1'b0;
        wr[0] = 1'b0;
        tick(1);
        chk("rst_access_no_ack", ack[0], 0);
        reset = 1'b1;
        tick(2);
        run_op(0, 1, 0, 16'h0030, 8'h00, 5, 0, 1, 1, 8'h99, 0);

        // Read held high for several clocks past ack: one cycle only.
        run_op(0, 1, 0, 16'h7FFF, 8'h00, 5, 0, 1, 1, 8'hC3, 5);

        // Settle sweep: SETTLE_CYCLES=1 and 15.
        run_op(1, 0, 1, 16'h0005, 8'h12, 2, 0, 0, 0, 8'h00, 0);
        run_op(1, 1, 0, 16'h0005, 8'h00, 2, 0, 1, 1, 8'h12, 0);
        run_op(2, 0, 1, 16'h0005, 8'h34, 16, 0, 0, 0, 8'h00, 0);
        run_op(2, 1, 0, 16'h0005, 8'h00, 16, 0, 1, 1, 8'h34, 0);

        tick(2);
        chk("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/relay_memory_responder.md
# relay_memory_responder

Bus-side responder for the relay computer's memory unit. It answers the sequencer's MEM-READ and MEM-WRITE requests on the 16-bit address bus and the 8-bit data bus. It models relay settle time with a programmable wait, then acknowledges with a four-phase handshake. It owns the memory array and drives the memory LED lamps. It sits opposite the instruction decoder/sequencer, which is the initiator of every memory cycle.

## Interface
Parameters:
- `ADDR_BITS`, 15: implemented address width (32 KiB array).
- `SETTLE_CYCLES`, 4: clocks between request capture and array access, modelling relay pull-in; legal range 1–15.

Ports:
- `clock` in 1: single clock. Everything is on its rising edge.
- `reset` in 1: synchronous, active-low (0 = reset).
- `mem_read` in 1: read request from the decoder.
- `mem_write` in 1: write request from the decoder.
- `addr` in 16: address bus.
- `data_in` in 8: data bus value to be written.
- `data_out` out 8: read data.
- `data_drive` out 1: responder is driving `data_out` onto the data bus.
- `mem_ack` out 1: cycle complete.
- `mem_err` out 1: error result for the current cycle.
- `led_busy` out 1: lamp, lit while a cycle is in progress.
- `led_addr` out 16: lamp, latched address.

## Operation
States are IDLE, SETTLE, ACCESS, DONE.

- **IDLE**
  - On `mem_read ^ mem_write`: latch `addr`, `data_in` and the op into internal registers. Load the settle counter with `SETTLE_CYCLES-1`. Go to SETTLE.
  - On `mem_read & mem_write`: latch nothing except `mem_err`=1. Go directly to DONE. No array access.
- **SETTLE**
  - Counter decrements each clock. At 0, go to ACCESS.
  - If the active request deasserts: abort to IDLE. No write occurs, no ack is raised, `mem_err` is unchanged.
- **ACCESS** (one clock)
  - Address range check: if `latched_addr[15:ADDR_BITS] != 0`, the access is out of range:
    - read returns 8'h00;
    - write is discarded;
    - `mem_err`=1.
  - Otherwise:
    - read loads `data_out` from the array;
    - write stores the latched data;
    - `mem_err`=0.
  - Go to DONE.
- **DONE**
  - `mem_ack`=1 and stays held.
  - `data_drive`=1 only if the op is a read.
  - When both requests are 0, go to IDLE. `mem_ack` and `data_drive` drop on that same edge.

Other rules:
- `data_out` holds its last read value until the next completed read. It is never changed by writes.
- `led_addr` updates only on capture in IDLE.
- `led_busy` = (state != IDLE).
- `mem_err` is valid while `mem_ack`=1. It holds until the next capture.
- Array contents are not cleared by reset. Simulation initial contents are undefined; the bench preloads them.

## Timing
- Reset values: state IDLE, `data_out`=8'h00, `data_drive`=0, `mem_ack`=0, `mem_err`=0, `led_busy`=0, `led_addr`=16'h0000, settle counter 0.
- Latency for a valid request: request sampled high at edge N → capture. `mem_ack` is high after edge N+`SETTLE_CYCLES`+1.
- Latency for a conflict request: `mem_ack` is high after edge N+1.
- Write commit happens at the ACCESS edge, N+`SETTLE_CYCLES`+1.
- Read data is valid coincident with `mem_ack` rising.
- Handshake: the initiator must hold the request until it sees `mem_ack`=1, then drop it. A request held high after DONE→IDLE is not re-captured until it has been seen low for at least one clock. Track this with a `req_seen_low` flag, set in IDLE when both requests are 0.
- Address and data changes after capture are ignored.
- Reset asserted in any state:
  - go to IDLE next edge;
  - an in-flight write that has not reached ACCESS is lost;
  - a write whose ACCESS edge coincides with reset does not commit, because reset has priority.

## Structure
- Shared package `relay_pkg`:
  - `mem_state_t` enum (IDLE, SETTLE, ACCESS, DONE);
  - `mem_op_t` enum (OP_READ, OP_WRITE);
  - `ADDR_W`=16 and `DATA_W`=8 constants.
- One sub-module, `relay_mem_array`: single-port synchronous RAM with depth 2^`ADDR_BITS`, inputs `we`/`addr`/`wdata`, registered `rdata`. It has no reset.
- FSM, counter and range check live in the top of this block.

## Test plan
- **Write then read:** with `SETTLE_CYCLES`=4, write 8'hA5 @16'h0123, then read @16'h0123 → `mem_ack` 5 clocks after each request, `data_out`=8'hA5, `data_drive`=1 only during the read's DONE, `mem_err`=0.
- **Out of range:** read @16'h8000 → `data_out`=8'h00, `mem_err`=1. Write 8'h3C @16'hFFFF, then read @16'h7FFF → the original 16'h7FFF contents are unchanged.
- **Conflict:** `mem_read`=`mem_write`=1 → `mem_ack` after 1 clock, `mem_err`=1, no array change at the latched address.
- **Abort:** write 8'h11 @16'h0010 with the request dropped 2 clocks into SETTLE → no `mem_ack`, back in IDLE. A subsequent read @16'h0010 returns the prior value.
- **Reset mid-operation:** assert `reset`=0 during SETTLE of a write of 8'h77 @16'h0020 → all outputs return to their reset values, and a read returns the prior value. Array contents elsewhere survive reset.
- **Held request:** hold `mem_read` high across DONE→IDLE → no second cycle until `mem_read` goes low for ≥1 clock. Also sweep `SETTLE_CYCLES`=1 and 15 and confirm the ack latency is `SETTLE_CYCLES`+1.
